heap_feeder: RTL

//  Upstream framing/sequencing stage for the heap sorter. Accepts a keyed record stream (valid/ready),

---
 rtl/heap_pkg.sv | 49 ++++
 rtl/heap_feeder_if.sv | 14 +
 rtl/heap_feeder_ctrl.sv | 88 ++++++++
 rtl/heap_feeder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// Shared heap word format helpers, flag constants and the feeder FSM state type.
// Word layout: {flag[1:0], payload, key}; widths up to WORD_MAX bits are supported.
package heap_pkg;

  localparam logic [1:0] FLAG_DATA  = 2'b00;
  localparam logic [1:0] FLAG_INIT  = 2'b01;
  localparam logic [1:0] FLAG_FLUSH = 2'b11;

  localparam int unsigned WORD_MAX = 64;
  typedef logic [WORD_MAX-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } feeder_state_t;

  function automatic word_t field_mask(input int unsigned width);
    return (width >= WORD_MAX) ? '1 : ((word_t'(1) << width) - word_t'(1));
  endfunction

  function automatic word_t pack_word(input logic [1:0] flag, input word_t payload,
                                      input word_t key, input int unsigned dw,
                                      input int unsigned kw);
    return (word_t'(flag) << (dw - 2)) |
           ((payload & field_mask(dw - 2 - kw)) << kw) |
           (key & field_mask(kw));
  endfunction

  function automatic logic [1:0] unpack_flag(input word_t w, input int unsigned dw);
    return 2'(w >> (dw - 2));
  endfunction

  function automatic word_t unpack_payload(input word_t w, input int unsigned dw,
                                           input int unsigned kw);
    return (w >> kw) & field_mask(dw - 2 - kw);
  endfunction

  function automatic word_t unpack_key(input word_t w, input int unsigned kw);
    return w & field_mask(kw);
  endfunction

  // Maximal key guarantees every held DATA element is popped ahead of it.
  function automatic word_t flush_word(input int unsigned dw, input int unsigned kw);
    return pack_word(FLAG_FLUSH, '0, '1, dw, kw);
  endfunction

endpackage

// File: rtl/heap_feeder_if.sv
// Keyed record stream (valid/ready) feeding the heap feeder.
interface heap_feeder_if #(
  parameter int unsigned KEY_WIDTH     = 16,
  parameter int unsigned PAYLOAD_WIDTH = 14
);
  logic                     valid;
  logic                     ready;
  logic [KEY_WIDTH-1:0]     key;
  logic [PAYLOAD_WIDTH-1:0] payload;
  logic                     last;

  modport master (output valid, key, payload, last, input ready);
  modport slave  (input valid, key, payload, last, output ready);
endinterface

// File: rtl/heap_feeder_ctrl.sv
// Frame sequencer for the heap feeder: IDLE -> INIT -> STREAM -> FLUSH -> IDLE,
// with the shared phase counter timing the INIT hold and the FLUSH injection.
module heap_feeder_ctrl
  import heap_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned FLUSH_COUNT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rec_fire,
  input  logic          rec_last,
  output feeder_state_t state,
  output logic          frame_start,
  output logic          heap_init,
  output logic          busy,
  output logic          done
);

  localparam int unsigned PHASE_MAX = (INIT_CYCLES > FLUSH_COUNT) ? INIT_CYCLES : FLUSH_COUNT;
  localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);

  logic [PHASE_W-1:0] phase_cnt;
  logic [PHASE_W-1:0] phase_nxt;
  feeder_state_t      state_nxt;
  logic               done_nxt;

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase_cnt;
    frame_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = INIT;
          phase_nxt   = '0;
          frame_start = 1'b1;
        end
      end
      INIT: begin
        if (phase_cnt == PHASE_W'(INIT_CYCLES - 1)) begin
          state_nxt = STREAM;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase_cnt + PHASE_W'(1);
        end
      end
      STREAM: begin
        if (rec_fire && rec_last) begin
          state_nxt = FLUSH;
          phase_nxt = '0;
        end
      end
      FLUSH: begin
        if (phase_cnt == PHASE_W'(FLUSH_COUNT - 1)) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else begin
          phase_nxt = phase_cnt + PHASE_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
    // done marks the final FLUSH cycle so a start seen alongside it is ignored.
    done_nxt = (state_nxt == FLUSH) && (phase_nxt == PHASE_W'(FLUSH_COUNT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      heap_init <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
      heap_init <= (state_nxt == INIT);
      busy      <= (state_nxt != IDLE);
      done      <= done_nxt;
    end
  end

endmodule

// File: rtl/heap_feeder.sv
// Heap sorter front end: packs records into heap words, sequences INIT/STREAM/FLUSH
// and registers the sorted DATA words back out. Option macro: HEAP_FEEDER_SEQ_TAG_EN.
module heap_feeder
  import heap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KEY_WIDTH   = 16,
  parameter int unsigned NLEVELS     = 2,
  parameter int unsigned INIT_CYCLES = 1 << NLEVELS,
  parameter int unsigned FLUSH_COUNT = 1 << (NLEVELS + 1),
  parameter int unsigned CNT_WIDTH   = 16,
  localparam int unsigned PW         = DATA_WIDTH - 2 - KEY_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  heap_feeder_if.slave          s,
  output logic [DATA_WIDTH-1:0] heap_din,
  output logic                  heap_en,
  output logic                  heap_init,
  input  logic [DATA_WIDTH-1:0] heap_dout,
  input  logic                  heap_valid,
  output logic                  m_valid,
  output logic [KEY_WIDTH-1:0]  m_key,
  output logic [PW-1:0]         m_payload,
  output logic [CNT_WIDTH-1:0]  m_count,
  output logic                  busy,
  output logic                  done
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  feeder_state_t state;
  logic          frame_start;
  logic          rec_fire;
  logic [PW-1:0] pay_field;
  logic          heap_is_data;

  logic                 vld_p1;
  logic [KEY_WIDTH-1:0] key_p1;
  logic [PW-1:0]        pay_p1;
  logic [CNT_WIDTH-1:0] cnt_p1;

  heap_feeder_ctrl #(
    .INIT_CYCLES (INIT_CYCLES),
    .FLUSH_COUNT (FLUSH_COUNT)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rec_fire    (rec_fire),
    .rec_last    (s.last),
    .state       (state),
    .frame_start (frame_start),
    .heap_init   (heap_init),
    .busy        (busy),
    .done        (done)
  );

  assign s.ready  = (state == STREAM);
  assign rec_fire = s.valid && s.ready;
  assign heap_en  = (state == FLUSH) || ((state == STREAM) && s.valid);

`ifdef HEAP_FEEDER_SEQ_TAG_EN
  logic [PW-1:0] seq_tag;

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      seq_tag <= '0;
    end else if (rec_fire) begin
      seq_tag <= seq_tag + PW'(1);
    end
  end

  assign pay_field = seq_tag;
`else
  assign pay_field = s.payload;
`endif

  // The heap samples din together with the combinational en, so the packed
  // word is presented in the same cycle rather than one register later.
  always_comb begin
    heap_din = '0;
    unique case (state)
      STREAM:  heap_din = DATA_WIDTH'(pack_word(FLAG_DATA, word_t'(pay_field),
                                                word_t'(s.key), DATA_WIDTH, KEY_WIDTH));
      FLUSH:   heap_din = DATA_WIDTH'(flush_word(DATA_WIDTH, KEY_WIDTH));
      default: heap_din = '0;
    endcase
  end

  assign heap_is_data = heap_valid &&
                        (unpack_flag(word_t'(heap_dout), DATA_WIDTH) == FLAG_DATA);

  // Stage p1: registered sorted output, INIT/FLUSH words dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      key_p1 <= '0;
      pay_p1 <= '0;
      cnt_p1 <= '0;
    end else begin
      vld_p1 <= heap_is_data;
      if (heap_is_data) begin
        key_p1 <= KEY_WIDTH'(unpack_key(word_t'(heap_dout), KEY_WIDTH));
        pay_p1 <= PW'(unpack_payload(word_t'(heap_dout), DATA_WIDTH, KEY_WIDTH));
      end
      if (frame_start) begin
        cnt_p1 <= '0;
      end else if (heap_is_data) begin
        cnt_p1 <= sat_inc(cnt_p1);
      end
    end
  end

  assign m_valid   = vld_p1;
  assign m_key     = key_p1;
  assign m_payload = pay_p1;
  assign m_count   = cnt_p1;

endmodule
